matmul_seq_ctrl: RTL

// Sequencer for the matrix-multiply datapath (X buffer, ALU, write-back, result SRAM).

---
 rtl/matmul_seq_ctrl_if.sv | 21 ++
 rtl/matmul_seq_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq_ctrl_if.sv
// Host-side streams of the matmul sequencer: X operands in, results out.
// master = host, slave = sequencer.
interface matmul_seq_ctrl_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [8:0] m_data;
  logic       m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Matmul sequencer: load X, run ALU, read results from SRAM, stream out.
// Optional MATMUL_TIMEOUT_EN adds a watchdog into a sticky ERR state.
module matmul_seq_ctrl #(
  parameter int X_WORDS     = 8,
  parameter int NUM_RESULTS = 16,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  matmul_seq_ctrl_if.slave  bus,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              input_load_en,
  output logic              valid_input,
  output logic [7:0]        X_load,
  input  logic              xload_done,
  output logic              ALU_en,
  input  logic              ALU_done,
  output logic              read_n,
  output logic [ADDR_W-1:0] r_addr,
  input  logic              ry,
  input  logic [8:0]        data_out
);

  localparam int CNT_W = $clog2(X_WORDS + 1);
  localparam logic [CNT_W-1:0] X_MAX = CNT_W'(X_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_RESULTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_RD_REQ,
    S_RD_WAIT,
    S_OUT,
    S_DONE,
    S_ERR
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
  logic [7:0]        x_load_q, x_load_d;
  logic              valid_input_q, valid_input_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [8:0]        m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              s_ready_q, s_ready_d;
  logic              load_en_q, load_en_d;
  logic              alu_en_q, alu_en_d;
  logic              read_n_q, read_n_d;

  logic s_fire;
  logic m_fire;
  logic wd_hit;

  assign s_fire = bus.s_valid & s_ready_q;
  assign m_fire = m_valid_q & bus.m_ready;

`ifdef MATMUL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            wd_run;

  assign wd_run = (state_q == S_COMPUTE) || (state_q == S_RD_WAIT);
  assign wd_hit = wd_run &&
                  ((32'(wdog_q) + 32'd1) == 32'(TIMEOUT_CYC));

  // Restart the count on entry to a waiting state, count while waiting
  always_comb begin
    wdog_d = wdog_q;
    if (state_d != state_q &&
        (state_d == S_COMPUTE || state_d == S_RD_WAIT)) begin
      wdog_d = '0;
    end else if (wd_run) begin
      wdog_d = wdog_q + WD_W'(1);
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  // Next-state, datapath handshakes and registered output values
  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    x_load_d      = x_load_q;
    valid_input_d = 1'b0;
    r_addr_d      = r_addr_q;
    m_data_d      = m_data_q;
    m_valid_d     = m_valid_q;
    m_last_d      = m_last_q;
    err_d         = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          load_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (s_fire) begin
          x_load_d      = bus.s_data;
          valid_input_d = 1'b1;
          load_cnt_d    = load_cnt_q + CNT_W'(1);
        end
        if (xload_done) begin
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (ALU_done) begin
          state_d  = S_RD_REQ;
          r_addr_d = '0;
        end else if (wd_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (ry) begin
          m_data_d  = data_out;
          m_valid_d = 1'b1;
          m_last_d  = (r_addr_q == LAST_ADDR);
          state_d   = S_OUT;
        end else if (wd_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_OUT: begin
        if (m_fire) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (m_last_q) begin
            state_d = S_DONE;
          end else begin
            r_addr_d = r_addr_q + ADDR_W'(1);
            state_d  = S_RD_REQ;
          end
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        load_cnt_d = '0;
      end
      S_ERR: begin
        if (start) begin
          err_d      = 1'b0;
          load_cnt_d = '0;
          state_d    = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d    = (state_d != S_IDLE) && (state_d != S_ERR);
    done_d    = (state_d == S_DONE);
    load_en_d = (state_d == S_LOAD);
    s_ready_d = (state_d == S_LOAD) && (load_cnt_d < X_MAX);
    alu_en_d  = (state_d == S_COMPUTE);
    read_n_d  = (state_d != S_RD_REQ);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      load_cnt_q    <= '0;
      x_load_q      <= '0;
      valid_input_q <= 1'b0;
      r_addr_q      <= '0;
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      s_ready_q     <= 1'b0;
      load_en_q     <= 1'b0;
      alu_en_q      <= 1'b0;
      read_n_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      x_load_q      <= x_load_d;
      valid_input_q <= valid_input_d;
      r_addr_q      <= r_addr_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      s_ready_q     <= s_ready_d;
      load_en_q     <= load_en_d;
      alu_en_q      <= alu_en_d;
      read_n_q      <= read_n_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign input_load_en = load_en_q;
  assign valid_input   = valid_input_q;
  assign X_load        = x_load_q;
  assign ALU_en        = alu_en_q;
  assign read_n        = read_n_q;
  assign r_addr        = r_addr_q;
  assign bus.s_ready   = s_ready_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_last    = m_last_q;

endmodule
